// File: rtl/f1_reaction_timer_if.sv
// f1_reaction_timer_if: start-light/button/result bundle between the sequence stage and the reaction timer.
// RT_BEST_TIME_EN adds the best_time result line.
interface f1_reaction_timer_if #(parameter int TIME_W = 16);
    logic              tick;
    logic [7:0]        lights_in;
    logic              btn;
    logic              hold_seq;
    logic [7:0]        lights_out;
    logic [TIME_W-1:0] reaction;
    logic              valid;
    logic              false_start;
`ifdef RT_BEST_TIME_EN
    logic [TIME_W-1:0] best_time;
`endif
    modport master (
`ifdef RT_BEST_TIME_EN
        input  best_time,
`endif
        output tick, lights_in, btn,
        input  hold_seq, lights_out, reaction, valid, false_start
    );
    modport slave (
`ifdef RT_BEST_TIME_EN
        output best_time,
`endif
        input  tick, lights_in, btn,
        output hold_seq, lights_out, reaction, valid, false_start
    );
endinterface

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: holds the lights at 8'hFF for a pseudo-random delay, then times the button press.
// RT_BEST_TIME_EN adds a best_time register tracking the fastest clean reaction since reset.
module f1_reaction_timer #(
    parameter int         TIME_W    = 16,
    parameter int         MIN_DELAY = 2,
    parameter logic [6:0] SEED      = 7'h01
) (
    input logic              clk,
    input logic              rst,
    f1_reaction_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, GO, DONE} state_t;
    localparam logic [TIME_W-1:0] MAX = '1;
    state_t            state_q, state_d;
    logic [6:0]        lfsr_q, lfsr_d;
    logic [7:0]        dcnt_q, dcnt_d, lights_q, lights_d;
    logic [TIME_W-1:0] rcnt_q, rcnt_d, reaction_q, reaction_d, rcnt_inc;
    logic              valid_q, valid_d, fs_q, fs_d, full_q, btn_q;
    logic              full, full_edge, btn_edge;
`ifdef RT_BEST_TIME_EN
    logic [TIME_W-1:0] best_q, best_d;
    assign bus.best_time = best_q;
`endif
    assign full            = bus.lights_in == 8'hFF;
    assign full_edge       = full & ~full_q;
    assign btn_edge        = bus.btn & ~btn_q;
    assign rcnt_inc        = (rcnt_q == MAX) ? MAX : rcnt_q + TIME_W'(1);
    // Combinational so the sequence FSM freezes in the very cycle 8'hFF appears
    assign bus.hold_seq    = (state_q != IDLE) | full_edge;
    assign bus.lights_out  = lights_q;
    assign bus.reaction    = reaction_q;
    assign bus.valid       = valid_q;
    assign bus.false_start = fs_q;
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        dcnt_d     = dcnt_q;
        rcnt_d     = rcnt_q;
        lights_d   = lights_q;
        reaction_d = reaction_q;
        fs_d       = fs_q;
        valid_d    = 1'b0;
`ifdef RT_BEST_TIME_EN
        best_d     = best_q;
`endif
        case (state_q)
            IDLE: begin
                lights_d = bus.lights_in;
                if (full_edge) begin
                    state_d = HOLD;
                    dcnt_d  = 8'(lfsr_q) + 8'(MIN_DELAY);
                    lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                end
            end
            HOLD: begin
                lights_d = 8'hFF;
                dcnt_d   = bus.tick ? dcnt_q - 8'd1 : dcnt_q;
                // A jump start wins even when the delay expires in the same cycle
                if (btn_edge) begin
                    state_d    = DONE;
                    fs_d       = 1'b1;
                    reaction_d = '0;
                end else if (bus.tick && dcnt_q == 8'd1) begin
                    state_d = GO;
                    rcnt_d  = '0;
                end
            end
            GO: begin
                lights_d = 8'h00;
                rcnt_d   = bus.tick ? rcnt_inc : rcnt_q;
                if (btn_edge) begin
                    state_d    = DONE;
                    fs_d       = 1'b0;
                    reaction_d = bus.tick ? rcnt_inc : rcnt_q;
                end
            end
            DONE: begin
                lights_d = 8'h00;
                valid_d  = 1'b1;
                state_d  = IDLE;
`ifdef RT_BEST_TIME_EN
                best_d   = (!fs_q && reaction_q < best_q) ? reaction_q : best_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            dcnt_q     <= '0;
            rcnt_q     <= '0;
            lights_q   <= '0;
            reaction_q <= '0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            full_q     <= 1'b0;
            btn_q      <= 1'b0;
`ifdef RT_BEST_TIME_EN
            best_q     <= '1;
`endif
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            dcnt_q     <= dcnt_d;
            rcnt_q     <= rcnt_d;
            lights_q   <= lights_d;
            reaction_q <= reaction_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
            full_q     <= full;
            btn_q      <= bus.btn;
`ifdef RT_BEST_TIME_EN
            best_q     <= best_d;
`endif
        end
    end
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: directed rounds with a result scoreboard drained by a valid-pulse monitor.
// A 4-bit reaction counter keeps saturation reachable in a short run.
module tb_f1_reaction_timer;
    localparam int TW = 4;
    typedef struct packed {
        logic [TW-1:0] r;
        logic          fs;
        logic [TW-1:0] best;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    logic [TW-1:0] best_m = '1;
    exp_t sb[$];
    always #5 clk = ~clk;
    f1_reaction_timer_if #(.TIME_W(TW)) bus();
    f1_reaction_timer #(.TIME_W(TW), .MIN_DELAY(2), .SEED(7'h01)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction
    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            if (sb.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("reaction", int'(bus.reaction), int'(e.r));
                check("false_start", int'(bus.false_start), int'(e.fs));
                check("lights_at_valid", int'(bus.lights_out), 0);
`ifdef RT_BEST_TIME_EN
                check("best_time", int'(bus.best_time), int'(e.best));
`endif
            end
        end
    end
    task automatic cyc(input logic t);
        bus.tick = t;
        @(posedge clk);
        #1;
    endtask
    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1);
            cyc(1'b0);
            cyc(1'b0);
        end
    endtask
    task automatic expect_res(input logic [TW-1:0] r, input logic fs);
        if (!fs && r < best_m) best_m = r;
        sb.push_back('{r: r, fs: fs, best: best_m});
    endtask
    task automatic press(input logic t);
        bus.btn = 1'b1;
        cyc(t);
        cyc(1'b0);
        cyc(1'b0);
        bus.btn = 1'b0;
        cyc(1'b0);
    endtask
    task automatic ramp();
        bus.lights_in = 8'h00;
        cyc(1'b0);
        for (int i = 0; i < 255; i++) begin
            bus.lights_in = 8'(i);
            cyc(1'b0);
        end
        check("hold_seq_pre_full", int'(bus.hold_seq), 0);
        bus.lights_in = 8'hFF;
        #1;
        check("hold_seq_same_cycle", int'(bus.hold_seq), 1);
        cyc(1'b0);
        check("lights_full", int'(bus.lights_out), 8'hFF);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    initial begin
        bus.tick = 1'b0;
        bus.btn = 1'b0;
        bus.lights_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lights", int'(bus.lights_out), 0);
        check("rst_reaction", int'(bus.reaction), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_false_start", int'(bus.false_start), 0);
        check("rst_hold_seq", int'(bus.hold_seq), 0);
`ifdef RT_BEST_TIME_EN
        check("rst_best", int'(bus.best_time), 15);
`endif
        rst = 1'b0;
        cyc(1'b0);
        ramp();
        ticks(2);
        check("r1_still_held", int'(bus.lights_out), 8'hFF);
        ticks(1);
        check("r1_lights_off", int'(bus.lights_out), 0);
        ticks(5);
        expect_res(4'd5, 1'b0);
        press(1'b0);
        ticks(2);
        check("no_rearm_hold", int'(bus.hold_seq), 0);
        check("no_rearm_lights", int'(bus.lights_out), 8'hFF);
        ramp();
        ticks(3);
        check("r2_still_held", int'(bus.lights_out), 8'hFF);
        ticks(1);
        check("r2_lights_off", int'(bus.lights_out), 0);
        ticks(9);
        expect_res(4'd9, 1'b0);
        press(1'b0);
        ramp();
        ticks(2);
        expect_res(4'd0, 1'b1);
        bus.btn = 1'b1;
        cyc(1'b0);
        check("fs_done_lights", int'(bus.lights_out), 8'hFF);
        check("fs_done_hold", int'(bus.hold_seq), 1);
        cyc(1'b0);
        check("fs_idle_hold", int'(bus.hold_seq), 0);
        bus.btn = 1'b0;
        cyc(1'b0);
        bus.lights_in = 8'h00;
        bus.btn = 1'b1;
        cyc(1'b0);
        ramp();
        ticks(10);
        check("held_btn_lights_off", int'(bus.lights_out), 0);
        check("held_btn_hold", int'(bus.hold_seq), 1);
        bus.btn = 1'b0;
        cyc(1'b0);
        ticks(2);
        expect_res(4'd2, 1'b0);
        press(1'b0);
        ramp();
        ticks(18);
        check("r5_lights_off", int'(bus.lights_out), 0);
        ticks(20);
        expect_res(4'hF, 1'b0);
        press(1'b0);
        ramp();
        ticks(34);
        ticks(3);
        expect_res(4'd4, 1'b0);
        press(1'b1);
        ramp();
        ticks(67);
        check("r7_lights_off", int'(bus.lights_out), 0);
        ticks(2);
        bus.lights_in = 8'h00;
        rst = 1'b1;
        best_m = '1;
        cyc(1'b0);
        rst = 1'b0;
        check("mid_rst_lights", int'(bus.lights_out), 0);
        check("mid_rst_hold", int'(bus.hold_seq), 0);
        check("mid_rst_valid", int'(bus.valid), 0);
        check("mid_rst_reaction", int'(bus.reaction), 0);
`ifdef RT_BEST_TIME_EN
        check("mid_rst_best", int'(bus.best_time), 15);
`endif
        cyc(1'b0);
        check("mid_rst_valid_after", int'(bus.valid), 0);
        ramp();
        ticks(2);
        check("seed_still_held", int'(bus.lights_out), 8'hFF);
        ticks(1);
        check("seed_lights_off", int'(bus.lights_out), 0);
        ticks(3);
        expect_res(4'd3, 1'b0);
        press(1'b0);
        repeat (4) cyc(1'b0);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
